right_rotor_stage: RTL

return-path (inverse-offset) rotor stage for the enigma datapath. It undoes the forward one-hot rotation. It keeps its own stepping rotor position and registers its output.

Interface

---
 rtl/right_rotor_stage_if.sv | 12 +
 rtl/right_rotor_stage.sv | 70 +++++++
 2 files changed

// File: rtl/right_rotor_stage_if.sv
// Character channel of the return-path rotor stage: one-hot letter in,
// translated one-hot letter out with a validity strobe and an error flag.
interface right_rotor_stage_if;
  logic        in_valid;
  logic [25:0] in;
  logic        out_valid;
  logic [25:0] out;
  logic        err;

  modport master (output in_valid, in, input out_valid, out, err);
  modport slave  (input in_valid, in, output out_valid, out, err);
endinterface

// File: rtl/right_rotor_stage.sv
// Return-path enigma rotor stage: subtracts its own stepping rotor position
// from a one-hot letter index, undoing the forward rotation, and registers the result.
module right_rotor_stage #(
  parameter int NOTCH = 25
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [5:0]                load_pos,
  input  logic                      step,
  right_rotor_stage_if.slave        chan,
  output logic [5:0]                pos,
  output logic                      carry
);

  localparam logic [5:0] notch_pos = 6'(NOTCH);

  logic        is_onehot;
  logic [5:0]  idx;
  logic [5:0]  diff;
  logic [25:0] decoded;

  // x & (x-1) clears the lowest set bit, so a non-zero x with nothing left is one-hot
  assign is_onehot = (chan.in != '0) && ((chan.in & (chan.in - 26'd1)) == '0);

  always_comb begin
    idx = '0;
    for (int k = 0; k < 26; k++) begin
      if (chan.in[k]) idx = 6'(k);
    end
  end

  // Modular subtraction kept in 6 bits: idx + 26 tops out at 51
  always_comb begin
    if (idx < pos) diff = idx + 6'd26 - pos;
    else           diff = idx - pos;
  end

  always_comb begin
    decoded = '0;
    for (int k = 0; k < 26; k++) begin
      if (diff == 6'(k)) decoded[k] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos            <= 6'd0;
      carry          <= 1'b0;
      chan.out       <= 26'h0000001;
      chan.out_valid <= 1'b0;
      chan.err       <= 1'b0;
    end else begin
      carry <= 1'b0;
      if (load) begin
        pos <= (load_pos > 6'd25) ? 6'd0 : load_pos;
      end else if (step) begin
        pos   <= (pos == 6'd25) ? 6'd0 : pos + 6'd1;
        carry <= (pos == notch_pos);
      end

      chan.out_valid <= chan.in_valid;
      chan.err       <= chan.in_valid && !is_onehot;
      if (chan.in_valid) begin
        chan.out <= is_onehot ? decoded : 26'h0000001;
      end
    end
  end

endmodule
